csr_exc_ctrl: RTL and testbench
===============================

// Module: csr_exc_ctrl
// PURPOSE
//  - MEM-stage exception/interrupt scheduler for the dual-issue (A/B) pipe.
//  - Arbitrates interrupt, A-slot exception, B-slot exception and ERTN into one CSR commit request.
//  - Drives the MEM_* exception inputs of the CSR pipeline register.
//  - Sequences the resulting pipeline flush, then re-arms.
// PARAMETERS
//  FLUSH_CYCLES  2      cycles the controller stays in FLUSH after an event (1..15)
//  ECODE_INT     7'h00  ecode written for an interrupt
// PORTS
//  clk               in   1   clock
//  rstn              in   1   reset: asynchronous, active-low
//  stall             in   1   stall_ex|stall_dcache; freezes the MEM stage
//  mem_a_enable      in   1   A slot holds a valid instruction
//  mem_b_enable      in   1   B slot holds a valid instruction
//  mem_pc_a          in   32  PC of the A slot
//  mem_pc_b          in   32  PC of the B slot
//  mem_ecode_a       in   7   ecode of the A slot
//  mem_ecode_b       in   7   ecode of the B slot
//  mem_ecode_we_a    in   1   A slot raised an exception
//  mem_ecode_we_b    in   1   B slot raised an exception
//  mem_badv_a        in   32  bad vaddr of the A slot
//  mem_badv_b        in   32  bad vaddr of the B slot
//  mem_badv_we_a     in   1   BADV write valid, A slot
//  mem_badv_we_b     in   1   BADV write valid, B slot
//  mem_ertn          in   1   ERTN in the B slot (always single-issued)
//  int_req           in   1   level: pending interrupt AND CRMD.IE
//  csr_eentry        in   32  current EENTRY
//  csr_era           in   32  current ERA
//  MEM_ecode_in      out  7   selected ecode
//  MEM_ecode_we      out  1   ESTAT.Ecode write
//  MEM_badv_in       out  32  selected BADV
//  MEM_badv_we       out  1   BADV write
//  MEM_era_in        out  32  PC to be saved in ERA
//  MEM_era_we        out  1   ERA write
//  MEM_store_state   out  1   PRMD<-CRMD on exception/interrupt
//  MEM_restore_state out  1   CRMD<-PRMD on ERTN
//  MEM_flush_csr     out  1   one-cycle flush request
//  MEM_flush_csr_pc  out  32  redirect target
//  busy              out  1   state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, int_pend=0, cnt=0, every output 0.
//  - Priority when any slot is valid and state==IDLE:
//      1. interrupt (int_req|int_pend): ERA = A valid ? pc_a : pc_b
//      2. A-slot exception: ERA = pc_a
//      3. B-slot exception (A valid without exception, or A invalid): ERA = pc_b
//      4. ERTN: no ERA/ecode write
//    The lower-priority slot is discarded.
//  - For priorities 1-3:
//      ecode_we=era_we=store_state=flush=1
//      flush_pc = csr_eentry
//      badv taken from the winning slot (badv_we=0 for an interrupt)
//  - For ERTN: restore_state=flush=1, flush_pc=csr_era.
//  - All MEM_* outputs are registered, 1-cycle latency from the sampled inputs, and high for exactly 1 cycle.
//  - Sampling happens only when !stall; during stall all outputs are held at 0 and the state is frozen.
//  - FSM:
//      IDLE->FLUSH on any event (cnt loads FLUSH_CYCLES-1)
//      FLUSH: decrement cnt each non-stall cycle; all new events are ignored (the pipe is being flushed); FLUSH->IDLE when cnt==0
//  - int_pend:
//      set when int_req=1, no slot valid and state==IDLE
//      cleared when the interrupt is taken or int_req falls
//      holds through FLUSH
//  - Simultaneous interrupt + exception: the interrupt wins, and int_pend clears.
//  - rstn low mid-FLUSH: immediate return to IDLE with outputs 0; no redirect is emitted.
// CONFIGURATION
//  - CSR_EXC_CTRL_STAT_EN defined adds:
//      exc_cnt out 32 (exceptions taken)
//      int_cnt out 32 (interrupts taken)
//    Both wrap at 2^32 and are reset to 0.
//  - Not defined: the ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  - A valid, ecode_we_a=1, ecode_a=7'h09, pc_a=0x1c000100
//      -> next cycle ecode_in=0x09, era_in=0x1c000100, flush_pc=eentry, flush=1 for 1 cycle
//  - Both slots valid, ecode_we_a=0, ecode_we_b=1, badv_b=0x3
//      -> era_in=pc_b, badv_in=0x3, badv_we=1
//  - int_req=1 with no valid slot for 3 cycles, then A valid
//      -> int_pend=1; on A valid: ecode_in=ECODE_INT, era_in=pc_a, int_pend->0
//  - ERTN with csr_era=0x1c000200
//      -> restore_state=1, flush_pc=0x1c000200, ecode_we=0
//  - Exception, then a second exception 1 cycle later (FLUSH_CYCLES=2)
//      -> the second is ignored; busy=1 for 2 cycles
//  - stall high during an event
//      -> outputs stay 0 until stall drops
//  - rstn pulse mid-FLUSH -> busy=0 at once

Source files
------------

// File: rtl/csr_exc_ctrl.sv
// MEM-stage exception/interrupt/ERTN scheduler for the dual-issue pipe: one CSR commit
// request per event, then a FLUSH_CYCLES-long flush window. Optional counters: CSR_EXC_CTRL_STAT_EN.
module csr_exc_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [6:0]  ECODE_INT    = 7'h00
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        stall,
   input  logic        mem_a_enable,
   input  logic        mem_b_enable,
   input  logic [31:0] mem_pc_a,
   input  logic [31:0] mem_pc_b,
   input  logic [6:0]  mem_ecode_a,
   input  logic [6:0]  mem_ecode_b,
   input  logic        mem_ecode_we_a,
   input  logic        mem_ecode_we_b,
   input  logic [31:0] mem_badv_a,
   input  logic [31:0] mem_badv_b,
   input  logic        mem_badv_we_a,
   input  logic        mem_badv_we_b,
   input  logic        mem_ertn,
   input  logic        int_req,
   input  logic [31:0] csr_eentry,
   input  logic [31:0] csr_era,
   output logic [6:0]  MEM_ecode_in,
   output logic        MEM_ecode_we,
   output logic [31:0] MEM_badv_in,
   output logic        MEM_badv_we,
   output logic [31:0] MEM_era_in,
   output logic        MEM_era_we,
   output logic        MEM_store_state,
   output logic        MEM_restore_state,
   output logic        MEM_flush_csr,
   output logic [31:0] MEM_flush_csr_pc,
   output logic        busy
`ifdef CSR_EXC_CTRL_STAT_EN
   ,
   output logic [31:0] exc_cnt,
   output logic [31:0] int_cnt
`endif
);

   typedef enum logic {IDLE, FLUSH} state_e;
   typedef enum logic [2:0] {EV_NONE, EV_INT, EV_EXC_A, EV_EXC_B, EV_ERTN} event_e;

   state_e     state;
   event_e     ev;
   logic [3:0] cnt;
   logic       int_pend;
   logic       any_valid;

   assign any_valid = mem_a_enable | mem_b_enable;
   assign busy      = (state == FLUSH);

   // Priority arbitration; only an idle, unstalled stage with a live slot can raise an event.
   // NOTE: ev gets its default before the if-chain so no path leaves it unassigned (no latch).
   always_comb begin
      ev = EV_NONE;
      if (state == IDLE && !stall && any_valid) begin
         if (int_req || int_pend)                  ev = EV_INT;
         else if (mem_a_enable && mem_ecode_we_a)  ev = EV_EXC_A;
         else if (mem_b_enable && mem_ecode_we_b)  ev = EV_EXC_B;
         else if (mem_b_enable && mem_ertn)        ev = EV_ERTN;
      end
   end

   // NOTE: all state and outputs share one clocked block with non-blocking assignments only,
   // and every output defaults to 0 each cycle, which makes each request a one-cycle pulse.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state             <= IDLE;
         cnt               <= '0;
         int_pend          <= 1'b0;
         MEM_ecode_in      <= '0;
         MEM_ecode_we      <= 1'b0;
         MEM_badv_in       <= '0;
         MEM_badv_we       <= 1'b0;
         MEM_era_in        <= '0;
         MEM_era_we        <= 1'b0;
         MEM_store_state   <= 1'b0;
         MEM_restore_state <= 1'b0;
         MEM_flush_csr     <= 1'b0;
         MEM_flush_csr_pc  <= '0;
`ifdef CSR_EXC_CTRL_STAT_EN
         exc_cnt           <= '0;
         int_cnt           <= '0;
`endif
      end else begin
         MEM_ecode_in      <= '0;
         MEM_ecode_we      <= 1'b0;
         MEM_badv_in       <= '0;
         MEM_badv_we       <= 1'b0;
         MEM_era_in        <= '0;
         MEM_era_we        <= 1'b0;
         MEM_store_state   <= 1'b0;
         MEM_restore_state <= 1'b0;
         MEM_flush_csr     <= 1'b0;
         MEM_flush_csr_pc  <= '0;

         if (!stall) begin
            case (ev)
               EV_INT: begin
                  MEM_ecode_in     <= ECODE_INT;
                  MEM_ecode_we     <= 1'b1;
                  MEM_era_in       <= mem_a_enable ? mem_pc_a : mem_pc_b;
                  MEM_era_we       <= 1'b1;
                  MEM_store_state  <= 1'b1;
                  MEM_flush_csr    <= 1'b1;
                  MEM_flush_csr_pc <= csr_eentry;
               end
               EV_EXC_A: begin
                  MEM_ecode_in     <= mem_ecode_a;
                  MEM_ecode_we     <= 1'b1;
                  MEM_badv_in      <= mem_badv_a;
                  MEM_badv_we      <= mem_badv_we_a;
                  MEM_era_in       <= mem_pc_a;
                  MEM_era_we       <= 1'b1;
                  MEM_store_state  <= 1'b1;
                  MEM_flush_csr    <= 1'b1;
                  MEM_flush_csr_pc <= csr_eentry;
               end
               EV_EXC_B: begin
                  MEM_ecode_in     <= mem_ecode_b;
                  MEM_ecode_we     <= 1'b1;
                  MEM_badv_in      <= mem_badv_b;
                  MEM_badv_we      <= mem_badv_we_b;
                  MEM_era_in       <= mem_pc_b;
                  MEM_era_we       <= 1'b1;
                  MEM_store_state  <= 1'b1;
                  MEM_flush_csr    <= 1'b1;
                  MEM_flush_csr_pc <= csr_eentry;
               end
               EV_ERTN: begin
                  MEM_restore_state <= 1'b1;
                  MEM_flush_csr     <= 1'b1;
                  MEM_flush_csr_pc  <= csr_era;
               end
               default: ;
            endcase

            case (state)
               IDLE: if (ev != EV_NONE) begin
                  state <= FLUSH;
                  cnt   <= 4'(FLUSH_CYCLES - 1);
               end
               FLUSH: if (cnt == '0) state <= IDLE;
                      else           cnt   <= cnt - 4'd1;
               default: state <= IDLE;
            endcase

            // A pending interrupt survives FLUSH and waits for the next live slot.
            if (ev == EV_INT || !int_req)         int_pend <= 1'b0;
            else if (state == IDLE && !any_valid) int_pend <= 1'b1;

`ifdef CSR_EXC_CTRL_STAT_EN
            if (ev == EV_INT)                      int_cnt <= int_cnt + 32'd1;
            if (ev == EV_EXC_A || ev == EV_EXC_B)  exc_cnt <= exc_cnt + 32'd1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_csr_exc_ctrl.sv
// Self-checking bench for csr_exc_ctrl: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the scheduling rules.
module tb_csr_exc_ctrl;

   localparam int unsigned FC   = 2;
   localparam logic [6:0]  EINT = 7'h00;

   logic        clk = 1'b0;
   logic        rstn;
   logic        stall, a_en, b_en, we_a, we_b, bwe_a, bwe_b, ertn, int_req;
   logic [31:0] pc_a, pc_b, badv_a, badv_b, eentry, era;
   logic [6:0]  ec_a, ec_b;
   logic [6:0]  o_ecode;
   logic        o_ecode_we, o_badv_we, o_era_we, o_store, o_restore, o_flush, o_busy;
   logic [31:0] o_badv, o_era, o_flush_pc;
`ifdef CSR_EXC_CTRL_STAT_EN
   logic [31:0] o_exc_cnt, o_int_cnt;
   int unsigned m_exc_cnt, m_int_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model state: outstanding busy cycles and the latched-interrupt flag.
   int unsigned m_left;
   bit          m_pend;

   always #5 clk = ~clk;

   csr_exc_ctrl #(.FLUSH_CYCLES(FC), .ECODE_INT(EINT)) dut (
      .clk(clk), .rstn(rstn), .stall(stall),
      .mem_a_enable(a_en), .mem_b_enable(b_en),
      .mem_pc_a(pc_a), .mem_pc_b(pc_b),
      .mem_ecode_a(ec_a), .mem_ecode_b(ec_b),
      .mem_ecode_we_a(we_a), .mem_ecode_we_b(we_b),
      .mem_badv_a(badv_a), .mem_badv_b(badv_b),
      .mem_badv_we_a(bwe_a), .mem_badv_we_b(bwe_b),
      .mem_ertn(ertn), .int_req(int_req),
      .csr_eentry(eentry), .csr_era(era),
      .MEM_ecode_in(o_ecode), .MEM_ecode_we(o_ecode_we),
      .MEM_badv_in(o_badv), .MEM_badv_we(o_badv_we),
      .MEM_era_in(o_era), .MEM_era_we(o_era_we),
      .MEM_store_state(o_store), .MEM_restore_state(o_restore),
      .MEM_flush_csr(o_flush), .MEM_flush_csr_pc(o_flush_pc),
      .busy(o_busy)
`ifdef CSR_EXC_CTRL_STAT_EN
      , .exc_cnt(o_exc_cnt), .int_cnt(o_int_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      stall = 0; a_en = 0; b_en = 0; we_a = 0; we_b = 0; bwe_a = 0; bwe_b = 0;
      ertn = 0; int_req = 0; ec_a = '0; ec_b = '0; badv_a = '0; badv_b = '0;
      pc_a = 32'h1c00_0000; pc_b = 32'h1c00_0004;
   endtask

   task automatic model_reset();
      m_left = 0;
      m_pend = 0;
`ifdef CSR_EXC_CTRL_STAT_EN
      m_exc_cnt = 0;
      m_int_cnt = 0;
`endif
   endtask

   // One clock: predict the outputs from the current inputs, clock, compare, advance the model.
   task automatic step(input string tag);
      logic [6:0]  e_ecode = '0;
      logic [31:0] e_badv = '0, e_era = '0, e_fpc = '0;
      logic        e_ecode_we = 0, e_badv_we = 0, e_era_we = 0, e_store = 0, e_restore = 0;
      logic        took_int = 0, took_exc = 0, fired;
      logic        any_v = a_en || b_en;
      logic        idle  = (m_left == 0);
      logic        a_exc = a_en && we_a;
      logic        b_exc = b_en && we_b && !a_exc;
      if (!stall && idle && any_v) begin
         if (int_req || m_pend) begin
            took_int = 1; e_ecode = EINT; e_ecode_we = 1; e_store = 1;
            e_era = a_en ? pc_a : pc_b; e_era_we = 1; e_fpc = eentry;
         end else if (a_exc) begin
            took_exc = 1; e_ecode = ec_a; e_ecode_we = 1; e_store = 1;
            e_badv = badv_a; e_badv_we = bwe_a; e_era = pc_a; e_era_we = 1; e_fpc = eentry;
         end else if (b_exc) begin
            took_exc = 1; e_ecode = ec_b; e_ecode_we = 1; e_store = 1;
            e_badv = badv_b; e_badv_we = bwe_b; e_era = pc_b; e_era_we = 1; e_fpc = eentry;
         end else if (b_en && ertn) begin
            e_restore = 1; e_fpc = era;
         end
      end
      fired = e_store || e_restore;

      @(posedge clk);
      #1;
      if (!stall) begin
         if (fired)           m_left = FC;
         else if (m_left > 0) m_left = m_left - 1;
         if (took_int || !int_req) m_pend = 0;
         else if (idle && !any_v)  m_pend = 1;
`ifdef CSR_EXC_CTRL_STAT_EN
         if (took_int) m_int_cnt++;
         if (took_exc) m_exc_cnt++;
`endif
      end
      check({tag, ".ctl"},
            {24'd0, o_ecode_we, o_badv_we, o_era_we, o_store, o_restore, o_flush, 2'b00},
            {24'd0, e_ecode_we, e_badv_we, e_era_we, e_store, e_restore, fired, 2'b00});
      check({tag, ".ecode"},    {25'd0, o_ecode}, {25'd0, e_ecode});
      check({tag, ".badv"},     o_badv, e_badv);
      check({tag, ".era"},      o_era, e_era);
      check({tag, ".flush_pc"}, o_flush_pc, e_fpc);
      check({tag, ".busy"},     {31'd0, o_busy}, {31'd0, m_left != 0});
   endtask

   initial begin
      clr();
      eentry = 32'h1c00_8000;
      era    = 32'h1c00_0200;
      rstn   = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset.flush", {31'd0, o_flush}, 32'd0);
      check("reset.busy",  {31'd0, o_busy}, 32'd0);
      check("reset.era",   o_era, 32'd0);
      @(negedge clk);
      rstn = 1;
      @(negedge clk);

      // A-slot exception
      a_en = 1; we_a = 1; ec_a = 7'h09; pc_a = 32'h1c00_0100;
      step("exc_a");
      check("exc_a.pc", o_era, 32'h1c00_0100);
      clr();
      repeat (3) step("exc_a.tail");

      // B-slot exception behind a clean A slot
      a_en = 1; b_en = 1; we_b = 1; ec_b = 7'h08; badv_b = 32'h3; bwe_b = 1;
      step("exc_b");
      check("exc_b.badv", o_badv, 32'h3);
      clr();
      repeat (2) step("exc_b.tail");

      // interrupt pending with no slot, then taken on A
      int_req = 1;
      repeat (3) step("int.wait");
      a_en = 1; we_a = 1; ec_a = 7'h0a; pc_a = 32'h1c00_0300;
      step("int.take");
      check("int.ecode", {25'd0, o_ecode}, {25'd0, EINT});
      clr();
      repeat (3) step("int.tail");

      // ERTN
      b_en = 1; ertn = 1;
      step("ertn");
      check("ertn.pc", o_flush_pc, 32'h1c00_0200);
      clr();
      repeat (2) step("ertn.tail");

      // back-to-back exceptions: the second lands in FLUSH and is dropped
      a_en = 1; we_a = 1; ec_a = 7'h01;
      step("b2b.first");
      ec_a = 7'h02; pc_a = 32'h1c00_0400;
      step("b2b.second");
      clr();
      repeat (2) step("b2b.tail");

      // stall during an event
      stall = 1; a_en = 1; we_a = 1; ec_a = 7'h05;
      repeat (2) step("stall.hold");
      stall = 0;
      step("stall.release");
      clr();
      repeat (2) step("stall.tail");

      // reset pulse mid-FLUSH
      a_en = 1; we_a = 1; ec_a = 7'h04;
      step("rst.event");
      clr();
      rstn = 0;
      #1;
      model_reset();
      check("rst.busy",  {31'd0, o_busy}, 32'd0);
      check("rst.flush", {31'd0, o_flush}, 32'd0);
      @(negedge clk);
      rstn = 1;
      step("rst.after");

      // random traffic
      for (int i = 0; i < 400; i++) begin
         stall   = ($urandom_range(0, 4) == 0);
         a_en    = $urandom_range(0, 1)[0];
         b_en    = $urandom_range(0, 1)[0];
         we_a    = ($urandom_range(0, 3) == 0);
         we_b    = ($urandom_range(0, 3) == 0);
         bwe_a   = $urandom_range(0, 1)[0];
         bwe_b   = $urandom_range(0, 1)[0];
         ertn    = ($urandom_range(0, 3) == 0);
         int_req = ($urandom_range(0, 5) == 0);
         ec_a    = 7'($urandom);
         ec_b    = 7'($urandom);
         pc_a    = $urandom;
         pc_b    = $urandom;
         badv_a  = $urandom;
         badv_b  = $urandom;
         eentry  = $urandom;
         era     = $urandom;
         step("rand");
      end

`ifdef CSR_EXC_CTRL_STAT_EN
      check("stat.exc", o_exc_cnt, m_exc_cnt);
      check("stat.int", o_int_cnt, m_int_cnt);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
